// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared constants for the host NBF AXI4-Lite front end: register offsets,
// AXI response codes and the write-path FSM encoding.
package blackparrot_fpga_host_pkg;

   localparam logic [3:0] host_nbf_data_addr_gp  = 4'h0;
   localparam logic [3:0] host_nbf_free_addr_gp  = 4'h4;
   localparam logic [3:0] host_nbf_count_addr_gp = 4'h8;
   localparam logic [3:0] host_nbf_ctrl_addr_gp  = 4'hC;

   localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
   localparam logic [1:0] axil_resp_slverr_gp = 2'b10;

   typedef enum logic [1:0] {
      e_wr_idle = 2'd0,
      e_wr_exec = 2'd1,
      e_wr_resp = 2'd2
   } host_nbf_wr_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with registered full/empty flags.
// The head word is presented combinationally from the storage array.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 32,
   parameter int els_p   = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_width_lp = $clog2(els_p);

   logic [width_p-1:0]      mem_r [els_p];
   logic [ptr_width_lp-1:0] wptr_r, rptr_r;
   logic                    full_r, empty_r;
   logic                    enq, deq;

   assign ready_o = ~full_r;
   assign v_o     = ~empty_r;
   assign data_o  = mem_r[rptr_r];

   assign enq = v_i & ~full_r;
   assign deq = yumi_i & ~empty_r;

   // Flags only move when occupancy actually changes; enq+deq together is a no-op.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else begin
         if (enq) wptr_r <= wptr_r + ptr_width_lp'(1);
         if (deq) rptr_r <= rptr_r + ptr_width_lp'(1);
         if (enq & ~deq) begin
            empty_r <= 1'b0;
            full_r  <= ((wptr_r + ptr_width_lp'(1)) == rptr_r);
         end else if (deq & ~enq) begin
            full_r  <= 1'b0;
            empty_r <= ((rptr_r + ptr_width_lp'(1)) == wptr_r);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/blackparrot_fpga_host_axil_nbf_fifo.sv
// AXI4-Lite slave that buffers host NBF words written to DATA into a FIFO,
// with FREE/COUNT status registers so software can pace its writes.
module blackparrot_fpga_host_axil_nbf_fifo
   import blackparrot_fpga_host_pkg::*;
#(
   parameter int s_axil_addr_width_p = 32,
   parameter int s_axil_data_width_p = 32,
   parameter int fifo_els_p          = 16
) (
   input  logic                             clk_i,
   input  logic                             reset_i,

   input  logic [s_axil_addr_width_p-1:0]   s_axil_awaddr_i,
   input  logic [2:0]                       s_axil_awprot_i,
   input  logic                             s_axil_awvalid_i,
   output logic                             s_axil_awready_o,

   input  logic [s_axil_data_width_p-1:0]   s_axil_wdata_i,
   input  logic [s_axil_data_width_p/8-1:0] s_axil_wstrb_i,
   input  logic                             s_axil_wvalid_i,
   output logic                             s_axil_wready_o,

   output logic [1:0]                       s_axil_bresp_o,
   output logic                             s_axil_bvalid_o,
   input  logic                             s_axil_bready_i,

   input  logic [s_axil_addr_width_p-1:0]   s_axil_araddr_i,
   input  logic [2:0]                       s_axil_arprot_i,
   input  logic                             s_axil_arvalid_i,
   output logic                             s_axil_arready_o,

   output logic [s_axil_data_width_p-1:0]   s_axil_rdata_o,
   output logic [1:0]                       s_axil_rresp_o,
   output logic                             s_axil_rvalid_o,
   input  logic                             s_axil_rready_i,

   output logic                             nbf_v_o,
   output logic [s_axil_data_width_p-1:0]   nbf_data_o,
   input  logic                             nbf_ready_and_i
);

   localparam int dw_lp        = s_axil_data_width_p;
   localparam int occ_width_lp = $clog2(fifo_els_p) + 1;

   // Handshakes: a beat transfers on a rising edge where valid and ready are
   // both high; valid never waits on ready, and ready depends only on state.
   host_nbf_wr_state_e wr_state_r, wr_state_n;

   logic                  aw_v_r, w_v_r;
   logic [3:0]            aw_addr_r;
   logic [dw_lp-1:0]      w_data_r;
   logic [dw_lp/8-1:0]    w_strb_r;
   logic                  aw_hs, w_hs;

   logic                  fifo_ready, push_v, pop_v, count_clr;
   logic [1:0]            exec_resp, bresp_r;
   logic                  exec_stall;
   logic [occ_width_lp-1:0] occ_r;
   logic [dw_lp-1:0]      count_r, free_w;

   logic                  rvalid_r, ar_hs;
   logic [dw_lp-1:0]      rdata_r;
   logic [1:0]            rresp_r;
   logic [3:0]            rd_addr;

   logic                  unused_inputs;
   assign unused_inputs = ^{s_axil_awprot_i, s_axil_arprot_i,
                            s_axil_awaddr_i[s_axil_addr_width_p-1:4],
                            s_axil_araddr_i[s_axil_addr_width_p-1:4]};

   assign aw_hs = s_axil_awvalid_i & s_axil_awready_o;
   assign w_hs  = s_axil_wvalid_i  & s_axil_wready_o;

   // A full-strobe DATA write into a full FIFO holds in EXEC until a pop frees space.
   assign exec_stall = (aw_addr_r == host_nbf_data_addr_gp) & (&w_strb_r) & ~fifo_ready;

   always_ff @(posedge clk_i) begin
      if (reset_i) wr_state_r <= e_wr_idle;
      else         wr_state_r <= wr_state_n;
   end

   always_comb begin
      wr_state_n = wr_state_r;
      case (wr_state_r)
         e_wr_idle: if ((aw_v_r | aw_hs) & (w_v_r | w_hs)) wr_state_n = e_wr_exec;
         e_wr_exec: if (~exec_stall) wr_state_n = e_wr_resp;
         e_wr_resp: if (s_axil_bready_i) wr_state_n = e_wr_idle;
         default:   wr_state_n = e_wr_idle;
      endcase
   end

   always_comb begin
      s_axil_awready_o = ~aw_v_r & (wr_state_r == e_wr_idle);
      s_axil_wready_o  = ~w_v_r  & (wr_state_r == e_wr_idle);
      s_axil_bvalid_o  = (wr_state_r == e_wr_resp);
      push_v           = 1'b0;
      count_clr        = 1'b0;
      exec_resp        = axil_resp_slverr_gp;
      if (wr_state_r == e_wr_exec) begin
         case (aw_addr_r)
            host_nbf_data_addr_gp: if (&w_strb_r) begin
               exec_resp = axil_resp_okay_gp;
               push_v    = fifo_ready;
            end
            host_nbf_ctrl_addr_gp: begin
               exec_resp = axil_resp_okay_gp;
               count_clr = w_data_r[0];
            end
            default: exec_resp = axil_resp_slverr_gp;
         endcase
      end
   end

   // Holding registers stay occupied until the B beat retires the write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         aw_v_r    <= 1'b0;
         w_v_r     <= 1'b0;
         aw_addr_r <= '0;
         w_data_r  <= '0;
         w_strb_r  <= '0;
         bresp_r   <= axil_resp_okay_gp;
      end else begin
         if (aw_hs) begin
            aw_v_r    <= 1'b1;
            aw_addr_r <= s_axil_awaddr_i[3:0];
         end else if (s_axil_bvalid_o & s_axil_bready_i) begin
            aw_v_r    <= 1'b0;
         end
         if (w_hs) begin
            w_v_r    <= 1'b1;
            w_data_r <= s_axil_wdata_i;
            w_strb_r <= s_axil_wstrb_i;
         end else if (s_axil_bvalid_o & s_axil_bready_i) begin
            w_v_r    <= 1'b0;
         end
         if ((wr_state_r == e_wr_exec) & ~exec_stall) bresp_r <= exec_resp;
      end
   end

   assign s_axil_bresp_o = bresp_r;

   assign pop_v = nbf_v_o & nbf_ready_and_i;

   bsg_fifo_1r1w_small #(
      .width_p (dw_lp),
      .els_p   (fifo_els_p)
   ) fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (push_v),
      .data_i  (w_data_r),
      .ready_o (fifo_ready),
      .v_o     (nbf_v_o),
      .data_o  (nbf_data_o),
      .yumi_i  (pop_v)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         occ_r   <= '0;
         count_r <= '0;
      end else begin
         case ({push_v, pop_v})
            2'b10:   occ_r <= occ_r + occ_width_lp'(1);
            2'b01:   occ_r <= occ_r - occ_width_lp'(1);
            default: occ_r <= occ_r;
         endcase
         if (count_clr)   count_r <= '0;
         else if (push_v) count_r <= count_r + dw_lp'(1);
      end
   end

   assign free_w = dw_lp'(fifo_els_p) - dw_lp'(occ_r);

   assign rd_addr          = s_axil_araddr_i[3:0];
   assign s_axil_arready_o = ~rvalid_r;
   assign ar_hs            = s_axil_arvalid_i & s_axil_arready_o;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rvalid_r <= 1'b0;
         rdata_r  <= '0;
         rresp_r  <= axil_resp_okay_gp;
      end else if (ar_hs) begin
         rvalid_r <= 1'b1;
         case (rd_addr)
            host_nbf_free_addr_gp: begin
               rdata_r <= free_w;
               rresp_r <= axil_resp_okay_gp;
            end
            host_nbf_count_addr_gp: begin
               rdata_r <= count_r;
               rresp_r <= axil_resp_okay_gp;
            end
            default: begin
               rdata_r <= '0;
               rresp_r <= axil_resp_slverr_gp;
            end
         endcase
      end else if (s_axil_rready_i) begin
         rvalid_r <= 1'b0;
      end
   end

   assign s_axil_rvalid_o = rvalid_r;
   assign s_axil_rdata_o  = rdata_r;
   assign s_axil_rresp_o  = rresp_r;

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_nbf_fifo.sv
// Directed bench for the host NBF AXI4-Lite FIFO: register map, write/read
// latency, back-pressure on a full FIFO, error responses and mid-flight reset.
module tb_blackparrot_fpga_host_axil_nbf_fifo;

   localparam logic [1:0] okay_c   = 2'b00;
   localparam logic [1:0] slverr_c = 2'b10;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic [31:0] awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        nbf_v;
   logic [31:0] nbf_data;
   logic        nbf_ready = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   blackparrot_fpga_host_axil_nbf_fifo dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .s_axil_awaddr_i  (awaddr),
      .s_axil_awprot_i  (awprot),
      .s_axil_awvalid_i (awvalid),
      .s_axil_awready_o (awready),
      .s_axil_wdata_i   (wdata),
      .s_axil_wstrb_i   (wstrb),
      .s_axil_wvalid_i  (wvalid),
      .s_axil_wready_o  (wready),
      .s_axil_bresp_o   (bresp),
      .s_axil_bvalid_o  (bvalid),
      .s_axil_bready_i  (bready),
      .s_axil_araddr_i  (araddr),
      .s_axil_arprot_i  (arprot),
      .s_axil_arvalid_i (arvalid),
      .s_axil_arready_o (arready),
      .s_axil_rdata_o   (rdata),
      .s_axil_rresp_o   (rresp),
      .s_axil_rvalid_o  (rvalid),
      .s_axil_rready_i  (rready),
      .nbf_v_o          (nbf_v),
      .nbf_data_o       (nbf_data),
      .nbf_ready_and_i  (nbf_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // All tasks start and end at a falling edge; handshakes are judged there.
   task automatic axil_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
      bit hs_aw, hs_w, hs_b, done;
      int n;
      awaddr = {28'h0, addr}; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      bready = 1'b1; done = 1'b0; n = 0; resp = 2'b11;
      while (!done && n < 100) begin
         hs_aw = awvalid & awready;
         hs_w  = wvalid & wready;
         hs_b  = bvalid & bready;
         if (hs_b) resp = bresp;
         step();
         if (hs_aw) awvalid = 1'b0;
         if (hs_w)  wvalid = 1'b0;
         if (hs_b)  done = 1'b1;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      chk("write_done", 32'(done), 32'd1);
   endtask

   task automatic axil_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
      bit hs, got;
      int n, lat;
      araddr = {28'h0, addr}; arvalid = 1'b1; rready = 1'b1;
      n = 0; got = 1'b0; lat = -1; data = '1; resp = 2'b11;
      while (arvalid && n < 50) begin
         hs = arready;
         step();
         if (hs) arvalid = 1'b0;
         n++;
      end
      n = 0;
      while (!got && n < 50) begin
         if (rvalid) begin
            data = rdata; resp = rresp; got = 1'b1; lat = n;
         end
         step();
         n++;
      end
      arvalid = 1'b0; rready = 1'b0;
      chk("read_latency", 32'(lat), 32'd0);
   endtask

   task automatic read_expect(input string tag, input logic [3:0] addr,
                              input logic [31:0] exp_data, input logic [1:0] exp_resp);
      logic [31:0] d;
      logic [1:0]  r;
      axil_read(addr, d, r);
      chk({tag, "_data"}, d, exp_data);
      chk({tag, "_resp"}, 32'(r), 32'(exp_resp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] r;
      logic [31:0] w;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd1);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_bresp", 32'(bresp), 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_nbf_v", 32'(nbf_v), 32'd0);
      read_expect("rst_free", 4'h4, 32'd16, okay_c);
      read_expect("rst_count", 4'h8, 32'd0, okay_c);

      // Single DATA write with AW and W together, exact cycle timing
      nbf_ready = 1'b1;
      awaddr = 32'h0; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
      chk("t1_awready", 32'(awready), 32'd1);
      chk("t1_wready", 32'(wready), 32'd1);
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("t1_n1_bvalid", 32'(bvalid), 32'd0);
      chk("t1_n1_nbf_v", 32'(nbf_v), 32'd0);
      step();
      chk("t1_n2_bvalid", 32'(bvalid), 32'd1);
      chk("t1_n2_bresp", 32'(bresp), 32'(okay_c));
      chk("t1_n2_nbf_v", 32'(nbf_v), 32'd1);
      chk("t1_n2_nbf_data", nbf_data, 32'hDEAD_BEEF);
      bready = 1'b1;
      step();
      bready = 1'b0;
      chk("t1_n3_bvalid", 32'(bvalid), 32'd0);
      chk("t1_n3_nbf_v", 32'(nbf_v), 32'd0);
      nbf_ready = 1'b0;
      read_expect("t1_count", 4'h8, 32'd1, okay_c);
      read_expect("t1_free", 4'h4, 32'd16, okay_c);

      // W three cycles ahead of AW
      wdata = 32'h1111_1111; wstrb = 4'hF; wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      step();
      chk("t2_wready_held", 32'(wready), 32'd0);
      chk("t2_awready_open", 32'(awready), 32'd1);
      step();
      awaddr = 32'h0; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      chk("t2_m1_awready", 32'(awready), 32'd0);
      chk("t2_m1_nbf_v", 32'(nbf_v), 32'd0);
      step();
      chk("t2_m2_nbf_v", 32'(nbf_v), 32'd1);
      chk("t2_m2_nbf_data", nbf_data, 32'h1111_1111);
      chk("t2_m2_bvalid", 32'(bvalid), 32'd1);
      chk("t2_m2_awready", 32'(awready), 32'd0);
      bready = 1'b1;
      step();
      bready = 1'b0;
      chk("t2_m3_awready", 32'(awready), 32'd1);
      nbf_ready = 1'b1;
      step();
      nbf_ready = 1'b0;
      chk("t2_drained", 32'(nbf_v), 32'd0);

      // Fill to 16, then a 17th write is back-pressured until one pop
      for (int i = 0; i < 16; i++) begin
         axil_write(4'h0, 32'h1000_0000 + 32'(i), 4'hF, r);
         exp_q.push_back(32'h1000_0000 + 32'(i));
         chk("fill_resp", 32'(r), 32'(okay_c));
      end
      read_expect("full_free", 4'h4, 32'd0, okay_c);
      read_expect("full_count", 4'h8, 32'd18, okay_c);
      awaddr = 32'h0; awvalid = 1'b1; wdata = 32'h1000_0010; wstrb = 4'hF; wvalid = 1'b1;
      bready = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (5) step();
      chk("stall_bvalid", 32'(bvalid), 32'd0);
      chk("stall_awready", 32'(awready), 32'd0);
      w = exp_q.pop_front();
      chk("stall_head", nbf_data, w);
      nbf_ready = 1'b1;
      step();
      nbf_ready = 1'b0;
      chk("stall_p1_bvalid", 32'(bvalid), 32'd0);
      step();
      chk("stall_p2_bvalid", 32'(bvalid), 32'd1);
      chk("stall_p2_bresp", 32'(bresp), 32'(okay_c));
      exp_q.push_back(32'h1000_0010);
      step();
      bready = 1'b0;
      nbf_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         w = exp_q.pop_front();
         chk("drain_v", 32'(nbf_v), 32'd1);
         chk("drain_data", nbf_data, w);
         step();
         n++;
      end
      nbf_ready = 1'b0;
      chk("drain_empty", 32'(nbf_v), 32'd0);
      read_expect("drain_count", 4'h8, 32'd19, okay_c);

      // Error responses and COUNT clear
      axil_write(4'h0, 32'hAAAA_5555, 4'h3, r);
      chk("partial_resp", 32'(r), 32'(slverr_c));
      chk("partial_no_push", 32'(nbf_v), 32'd0);
      axil_write(4'h8, 32'h0000_0001, 4'hF, r);
      chk("wr_count_resp", 32'(r), 32'(slverr_c));
      axil_write(4'h4, 32'h0000_0001, 4'hF, r);
      chk("wr_free_resp", 32'(r), 32'(slverr_c));
      read_expect("err_count", 4'h8, 32'd19, okay_c);
      read_expect("err_free", 4'h4, 32'd16, okay_c);
      read_expect("rd_data_reg", 4'h0, 32'd0, slverr_c);
      read_expect("rd_unmapped", 4'h6, 32'd0, slverr_c);
      axil_write(4'hC, 32'h0000_0001, 4'hF, r);
      chk("ctrl_resp", 32'(r), 32'(okay_c));
      read_expect("clr_count", 4'h8, 32'd0, okay_c);

      // Reset while B is pending with five words buffered
      for (int i = 0; i < 4; i++) begin
         axil_write(4'h0, 32'h2000_0000 + 32'(i), 4'hF, r);
         chk("pre_rst_resp", 32'(r), 32'(okay_c));
      end
      awaddr = 32'h0; awvalid = 1'b1; wdata = 32'h2000_0004; wstrb = 4'hF; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 10) begin
         step();
         n++;
      end
      chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
      read_expect("pre_rst_free", 4'h4, 32'd11, okay_c);
      read_expect("pre_rst_count", 4'h8, 32'd5, okay_c);
      chk("pre_rst_b_held", 32'(bvalid), 32'd1);
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      chk("post_rst_bvalid", 32'(bvalid), 32'd0);
      chk("post_rst_nbf_v", 32'(nbf_v), 32'd0);
      chk("post_rst_awready", 32'(awready), 32'd1);
      chk("post_rst_wready", 32'(wready), 32'd1);
      read_expect("post_rst_free", 4'h4, 32'd16, okay_c);
      read_expect("post_rst_count", 4'h8, 32'd0, okay_c);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
